// File: rtl/onehot_hold_decoder.sv
// onehot_hold_decoder: strobed 2-bit channel index -> 3 stretched one-hot lines.
// Each line holds for HOLD cycles after its strobe (retriggerable); EXCL makes
// a strobe cancel the other lines. Illegal index 3 sets a sticky ERR.

// One channel: retriggerable 8-bit hold counter, line is high while non-zero.
module onehot_hold_chan #(
    parameter logic [7:0] HOLD_V = 8'd8
) (
    input  logic CLK,
    input  logic nRST,
    input  logic load,   // restart the hold
    input  logic kill,   // force the hold to zero (clear or exclusive cancel)
    output logic active
);
    logic [7:0] cnt_q, cnt_d;

    // Next count: kill beats load beats saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (kill)
            cnt_d = 8'd0;
        else if (load)
            cnt_d = HOLD_V;
        else if (cnt_q != 8'd0)
            cnt_d = cnt_q - 8'd1;
    end

    // Counter register; reset drops any hold in progress.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

    assign active = (cnt_q != 8'd0);
endmodule

module onehot_hold_decoder #(
    parameter int HOLD = 8,
    parameter bit EXCL = 1'b1
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       STB,
    input  logic [1:0] Din,
    input  logic       CLR,
    output logic [2:0] Dout,
    output logic       ACT,
    output logic       ERR
);
    localparam int         NUM_LANES = 3;
    localparam logic [7:0] HOLD_V    = HOLD[7:0];

    // Reject hold values the 8-bit counters cannot represent (0 would never assert).
    if ((HOLD < 1) || (HOLD > 255)) begin : g_hold_chk
        $error("onehot_hold_decoder: HOLD=%0d outside 1..255", HOLD);
    end

    logic                 legal_stb;
    logic                 err_q, err_d;
    logic [NUM_LANES-1:0] load, kill;

    assign legal_stb = STB && (Din != 2'd3);

    // Per-lane load/kill decode and hold counter.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign load[i] = legal_stb && !CLR && (Din == 2'(i));
        assign kill[i] = CLR || (EXCL && legal_stb && (Din != 2'(i)));

        onehot_hold_chan #(.HOLD_V(HOLD_V)) u_chan (
            .CLK    (CLK),
            .nRST   (nRST),
            .load   (load[i]),
            .kill   (kill[i]),
            .active (Dout[i])
        );
    end

    // Sticky error: set by an illegal strobe, cleared only by CLR (which wins).
    always_comb begin
        err_d = err_q;
        if (CLR)
            err_d = 1'b0;
        else if (STB && (Din == 2'd3))
            err_d = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign ERR = err_q;
    assign ACT = |Dout;
endmodule

// File: tb/tb_onehot_hold_decoder.sv
// Bench for onehot_hold_decoder: three instances (HOLD=8 exclusive, HOLD=8
// independent, HOLD=1 independent) share stimulus. A timestamp model predicts
// {ACT,ERR,Dout} per edge; predictions are queued and popped after the edge.
module tb_onehot_hold_decoder;
    localparam int NI = 3;

    logic       CLK, nRST, STB, CLR;
    logic [1:0] Din;
    logic [2:0] dout [NI];
    logic       act  [NI];
    logic       err  [NI];

    onehot_hold_decoder #(.HOLD(8), .EXCL(1'b1)) u_h8x (
        .CLK(CLK), .nRST(nRST), .STB(STB), .Din(Din), .CLR(CLR),
        .Dout(dout[0]), .ACT(act[0]), .ERR(err[0]));
    onehot_hold_decoder #(.HOLD(8), .EXCL(1'b0)) u_h8i (
        .CLK(CLK), .nRST(nRST), .STB(STB), .Din(Din), .CLR(CLR),
        .Dout(dout[1]), .ACT(act[1]), .ERR(err[1]));
    onehot_hold_decoder #(.HOLD(1), .EXCL(1'b0)) u_h1i (
        .CLK(CLK), .nRST(nRST), .STB(STB), .Din(Din), .CLR(CLR),
        .Dout(dout[2]), .ACT(act[2]), .ERR(err[2]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // Model: a line is high after edge t while its expiry stamp is > t.
    int   t = 0;
    int   exp_t [NI][3];
    bit   m_err [NI];
    int   hold_p [NI] = '{8, 8, 1};
    bit   excl_p [NI] = '{1'b1, 1'b0, 1'b0};
    logic [4:0] sb [$];

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got {ACT,ERR,Dout}=%b want %b (t=%0d)", tag, got, want, t);
        end
    endtask

    function automatic logic [4:0] predict(input int n);
        logic [2:0] d;
        for (int i = 0; i < 3; i++) d[i] = (exp_t[n][i] > t);
        return {|d, m_err[n], d};
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NI; n++) begin
            for (int i = 0; i < 3; i++) exp_t[n][i] = t;
            m_err[n] = 1'b0;
        end
    endtask

    // Advance the model for the coming edge, queue predictions, clock, compare.
    task automatic step(input string tag);
        t++;
        if (!nRST) model_reset();
        else begin
            for (int n = 0; n < NI; n++) begin
                if (CLR) begin
                    for (int i = 0; i < 3; i++) exp_t[n][i] = t;
                    m_err[n] = 1'b0;
                end else if (STB && Din != 2'd3) begin
                    for (int i = 0; i < 3; i++)
                        if (i == int'(Din)) exp_t[n][i] = t + hold_p[n];
                        else if (excl_p[n] && exp_t[n][i] > t) exp_t[n][i] = t;
                end else if (STB) begin
                    m_err[n] = 1'b1;
                end
            end
        end
        for (int n = 0; n < NI; n++) sb.push_back(predict(n));
        @(posedge CLK);
        #1;
        for (int n = 0; n < NI; n++) begin
            logic [4:0] e;
            e = sb.pop_front();
            chk($sformatf("%s/u%0d", tag, n), {act[n], err[n], dout[n]}, e);
        end
        STB = 1'b0;
        CLR = 1'b0;
    endtask

    task automatic strobe(input logic [1:0] d, input string tag);
        STB = 1'b1; Din = d; step(tag);
    endtask

    task automatic idle(input int k, input string tag);
        for (int j = 0; j < k; j++) step(tag);
    endtask

    initial begin
        nRST = 1'b0; STB = 1'b0; Din = 2'd0; CLR = 1'b0;
        model_reset();
        #1;
        for (int n = 0; n < NI; n++)
            chk($sformatf("reset/u%0d", n), {act[n], err[n], dout[n]}, 5'b0);
        idle(3, "rst_hold");
        nRST = 1'b1;

        // Single event on channel 1
        strobe(2'd1, "single");
        idle(10, "single_tail");

        // Retrigger channel 0 at edge 0 and edge 5
        strobe(2'd0, "retrig0");
        idle(4, "retrig_mid");
        strobe(2'd0, "retrig5");
        idle(10, "retrig_tail");

        // Channel switch 2 -> 0 three edges apart
        strobe(2'd2, "sw2");
        idle(2, "sw_mid");
        strobe(2'd0, "sw0");
        idle(10, "sw_tail");

        // Overlapping channels 0 then 2
        strobe(2'd0, "ov0");
        idle(1, "ov_mid");
        strobe(2'd2, "ov2");
        idle(10, "ov_tail");

        // Illegal index while channel 1 holds, then CLR with a strobe
        strobe(2'd1, "il1");
        idle(2, "il_mid");
        strobe(2'd3, "illegal");
        idle(2, "il_hold");
        CLR = 1'b1; STB = 1'b1; Din = 2'd0;
        step("clr_stb");
        idle(2, "clr_tail");
        CLR = 1'b1; STB = 1'b1; Din = 2'd3;
        step("clr_illegal");

        // Back-to-back strobes keep a line continuously high
        strobe(2'd1, "b2b");
        strobe(2'd1, "b2b");
        strobe(2'd1, "b2b");
        idle(9, "b2b_tail");

        // Asynchronous reset in the middle of a hold
        strobe(2'd2, "ar_load");
        idle(3, "ar_mid");
        #3;
        nRST = 1'b0;
        #1;
        model_reset();
        for (int n = 0; n < NI; n++)
            chk($sformatf("async_rst/u%0d", n), {act[n], err[n], dout[n]}, predict(n));
        idle(2, "ar_low");
        nRST = 1'b1;
        idle(9, "ar_after");

        // Release edge accepts a strobe
        nRST = 1'b0;
        idle(1, "rel_low");
        nRST = 1'b1;
        strobe(2'd2, "rel_strobe");
        idle(9, "rel_tail");

        // Random traffic
        for (int j = 0; j < 300; j++) begin
            STB = ($urandom_range(0, 2) != 0);
            Din = 2'($urandom_range(0, 3));
            CLR = ($urandom_range(0, 24) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
